// File: rtl/gpio_pcint_pkg.sv
// Shared constants, register-select enum and address decode helper for the GPIO port.
// Default register offsets live here; the top can override each one by parameter.
package gpio_pcint_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    localparam logic [ADDR_W-1:0] PIN_ADDR_DEF   = 6'h00;
    localparam logic [ADDR_W-1:0] DDR_ADDR_DEF   = 6'h01;
    localparam logic [ADDR_W-1:0] PORT_ADDR_DEF  = 6'h02;
    localparam logic [ADDR_W-1:0] PCMSK_ADDR_DEF = 6'h03;
    localparam logic [ADDR_W-1:0] PCIFR_ADDR_DEF = 6'h04;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PIN,
        REG_DDR,
        REG_PORT,
        REG_PCMSK,
        REG_PCIFR
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] pin_a,
        input logic [ADDR_W-1:0] ddr_a,
        input logic [ADDR_W-1:0] port_a,
        input logic [ADDR_W-1:0] pcmsk_a,
        input logic [ADDR_W-1:0] pcifr_a
    );
        reg_sel_e sel;
        sel = REG_NONE;
        if (addr == pin_a)        sel = REG_PIN;
        else if (addr == ddr_a)   sel = REG_DDR;
        else if (addr == port_a)  sel = REG_PORT;
        else if (addr == pcmsk_a) sel = REG_PCMSK;
        else if (addr == pcifr_a) sel = REG_PCIFR;
        return sel;
    endfunction

endpackage

// File: rtl/gpio_pcint_if.sv
// rAVR 6-bit I/O bus as seen by one peripheral: address, strobes and both data directions.
interface gpio_pcint_if;
    import gpio_pcint_pkg::*;

    logic [ADDR_W-1:0] io_a;
    logic [DATA_W-1:0] io_di;
    logic [DATA_W-1:0] io_do;
    logic              io_re;
    logic              io_we;

    modport master (output io_a, io_di, io_re, io_we, input io_do);
    modport slave  (input io_a, io_di, io_re, io_we, output io_do);

endinterface

// File: rtl/gpio_sync_filter.sv
// One pad input: SYNC_STAGES-deep synchroniser, plus a stability counter when
// GPIO_DEBOUNCE_EN is defined; otherwise pin_val is the synchroniser output.
module gpio_sync_filter #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES  = 16
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic pin_in,
    output logic pin_val
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_q <= '0;
        else            sync_q <= sync_d;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             val_q, val_d;

    // A new level is accepted only after it has differed from pin_val for DEB_CYCLES cycles.
    always_comb begin
        cnt_d = cnt_q;
        val_d = val_q;
        if (sync_out == val_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            val_d = sync_out;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            val_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
        end
    end

    assign pin_val = val_q;
`else
    assign pin_val = sync_out;
`endif

endmodule

// File: rtl/gpio_pcint.sv
// rAVR GPIO port with PIN-write toggle and masked pin-change interrupt (W1C flags).
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_pcint
    import gpio_pcint_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] PIN_ADDR    = PIN_ADDR_DEF,
    parameter logic [ADDR_W-1:0] DDR_ADDR    = DDR_ADDR_DEF,
    parameter logic [ADDR_W-1:0] PORT_ADDR   = PORT_ADDR_DEF,
    parameter logic [ADDR_W-1:0] PCMSK_ADDR  = PCMSK_ADDR_DEF,
    parameter logic [ADDR_W-1:0] PCIFR_ADDR  = PCIFR_ADDR_DEF
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int                DEB_CYCLES  = 16
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    gpio_pcint_if.slave      bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_ddr,
    output logic             irq
);

    logic [WIDTH-1:0]  pin_val;
    logic [WIDTH-1:0]  chg;
    logic [WIDTH-1:0]  wdata;
    reg_sel_e          wr_sel, rd_sel;

    logic [WIDTH-1:0]  ddr_q, ddr_d;
    logic [WIDTH-1:0]  port_q, port_d;
    logic [WIDTH-1:0]  pcmsk_q, pcmsk_d;
    logic [WIDTH-1:0]  pcifr_q, pcifr_d;
    logic [WIDTH-1:0]  pin_dly_q, pin_dly_d;
    logic [DATA_W-1:0] io_do_q, io_do_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_sync_filter #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            ,
            .DEB_CYCLES  (DEB_CYCLES)
`endif
        ) u_filter (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .pin_in    (pin_in[i]),
            .pin_val   (pin_val[i])
        );
    end

    assign wdata = bus.io_di[WIDTH-1:0];
    assign chg   = pin_val ^ pin_dly_q;

    always_comb begin
        wr_sel = REG_NONE;
        rd_sel = REG_NONE;
        if (bus.io_we)
            wr_sel = decode_addr(bus.io_a, PIN_ADDR, DDR_ADDR, PORT_ADDR, PCMSK_ADDR, PCIFR_ADDR);
        if (bus.io_re)
            rd_sel = decode_addr(bus.io_a, PIN_ADDR, DDR_ADDR, PORT_ADDR, PCMSK_ADDR, PCIFR_ADDR);
    end

    // Reads sample the current (pre-write) registers; flag sets are ORed in after the W1C.
    always_comb begin
        ddr_d     = ddr_q;
        port_d    = port_q;
        pcmsk_d   = pcmsk_q;
        pcifr_d   = pcifr_q;
        pin_dly_d = pin_val;
        io_do_d   = '0;

        case (wr_sel)
            REG_PIN:   port_d  = port_q ^ wdata;
            REG_DDR:   ddr_d   = wdata;
            REG_PORT:  port_d  = wdata;
            REG_PCMSK: pcmsk_d = wdata;
            REG_PCIFR: pcifr_d = pcifr_q & ~wdata;
            default:   ;
        endcase

        pcifr_d = pcifr_d | (chg & pcmsk_q);

        case (rd_sel)
            REG_PIN:   io_do_d = DATA_W'(pin_val);
            REG_DDR:   io_do_d = DATA_W'(ddr_q);
            REG_PORT:  io_do_d = DATA_W'(port_q);
            REG_PCMSK: io_do_d = DATA_W'(pcmsk_q);
            REG_PCIFR: io_do_d = DATA_W'(pcifr_q);
            default:   io_do_d = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ddr_q     <= '0;
            port_q    <= '0;
            pcmsk_q   <= '0;
            pcifr_q   <= '0;
            pin_dly_q <= '0;
            io_do_q   <= '0;
        end else begin
            ddr_q     <= ddr_d;
            port_q    <= port_d;
            pcmsk_q   <= pcmsk_d;
            pcifr_q   <= pcifr_d;
            pin_dly_q <= pin_dly_d;
            io_do_q   <= io_do_d;
        end
    end

    assign bus.io_do = io_do_q;
    assign pin_out   = port_q;
    assign pin_ddr   = ddr_q;
    assign irq       = |pcifr_q;

endmodule

// File: tb/tb_gpio_pcint.sv
// Scoreboard bench for gpio_pcint: an 8-pin and a 4-pin instance share clock and reset.
// Read expectations are queued when the read is driven and checked when io_do appears.
module tb_gpio_pcint;

    localparam logic [5:0] A_PIN   = 6'h00;
    localparam logic [5:0] A_DDR   = 6'h01;
    localparam logic [5:0] A_PORT  = 6'h02;
    localparam logic [5:0] A_PCMSK = 6'h03;
    localparam logic [5:0] A_PCIFR = 6'h04;
    localparam logic [5:0] A_NONE  = 6'h3F;
    localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int FLT = 16;
`else
    localparam int FLT = 0;
`endif

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sbEntry_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] pinIn8, pinOut8, pinDdr8;
    logic [3:0] pinIn4, pinOut4, pinDdr4;
    logic       irq8, irq4;

    sbEntry_t sb8[$];
    sbEntry_t sb4[$];
    logic     rdSeen8 = 1'b0;
    logic     rdSeen4 = 1'b0;
    int       numCompared = 0;
    int       numMismatched = 0;

    gpio_pcint_if bus8();
    gpio_pcint_if bus4();

    gpio_pcint #(.WIDTH(8)) dut8 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus8.slave),
        .pin_in    (pinIn8),
        .pin_out   (pinOut8),
        .pin_ddr   (pinDdr8),
        .irq       (irq8)
    );

    gpio_pcint #(.WIDTH(4)) dut4 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus4.slave),
        .pin_in    (pinIn4),
        .pin_out   (pinOut4),
        .pin_ddr   (pinDdr4),
        .irq       (irq4)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle on either instance; for reads, data is the expected io_do value.
    task automatic applyStimulus(input bit narrow, input bit isWrite, input logic [5:0] addr,
                                 input logic [7:0] data, input string tag);
        sbEntry_t e;
        e.tag = tag;
        e.exp = data;
        if (!narrow) begin
            bus8.io_a = addr;
            bus8.io_di = data;
            if (isWrite) bus8.io_we = 1'b1;
            else begin bus8.io_re = 1'b1; sb8.push_back(e); end
        end else begin
            bus4.io_a = addr;
            bus4.io_di = data;
            if (isWrite) bus4.io_we = 1'b1;
            else begin bus4.io_re = 1'b1; sb4.push_back(e); end
        end
        @(negedge sys_clk);
        bus8.io_we = 1'b0;
        bus8.io_re = 1'b0;
        bus4.io_we = 1'b0;
        bus4.io_re = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    always @(posedge sys_clk) begin
        rdSeen8 <= bus8.io_re;
        rdSeen4 <= bus4.io_re;
    end

    // Read data is registered, so it is valid at the negedge after the strobe's edge.
    always @(negedge sys_clk) begin
        sbEntry_t e;
        if (rdSeen8) begin
            if (sb8.size() == 0) checkOutput("sb8_underflow", 8'd0, 8'd1);
            else begin
                e = sb8.pop_front();
                checkOutput(e.tag, bus8.io_do, e.exp);
            end
        end
        if (rdSeen4) begin
            if (sb4.size() == 0) checkOutput("sb4_underflow", 8'd0, 8'd1);
            else begin
                e = sb4.pop_front();
                checkOutput(e.tag, bus4.io_do, e.exp);
            end
        end
    end

    initial begin
        sys_rst_n  = 1'b0;
        pinIn8     = 8'h00;
        pinIn4     = 4'h0;
        bus8.io_a  = '0; bus8.io_di = '0; bus8.io_re = 1'b0; bus8.io_we = 1'b0;
        bus4.io_a  = '0; bus4.io_di = '0; bus4.io_re = 1'b0; bus4.io_we = 1'b0;
        waitCycles(3);
        sys_rst_n = 1'b1;
        waitCycles(1);

        $display("[TB] reset state");
        checkOutput("irq_rst", 8'(irq8), 8'h00);
        checkOutput("ddr_pad_rst", pinDdr8, 8'h00);
        checkOutput("port_pad_rst", pinOut8, 8'h00);
        applyStimulus(0, 0, A_PIN,   8'h00, "rd_pin_rst");
        applyStimulus(0, 0, A_DDR,   8'h00, "rd_ddr_rst");
        applyStimulus(0, 0, A_PORT,  8'h00, "rd_port_rst");
        applyStimulus(0, 0, A_PCMSK, 8'h00, "rd_pcmsk_rst");
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_rst");

        $display("[TB] register access and PIN toggle");
        applyStimulus(0, 1, A_DDR,  8'hF0, "wr_ddr");
        applyStimulus(0, 1, A_PORT, 8'hA5, "wr_port");
        applyStimulus(0, 0, A_DDR,  8'hF0, "rd_ddr");
        applyStimulus(0, 0, A_PORT, 8'hA5, "rd_port");
        checkOutput("ddr_pad", pinDdr8, 8'hF0);
        checkOutput("port_pad", pinOut8, 8'hA5);
        applyStimulus(0, 1, A_PIN,  8'h0F, "wr_pin_toggle");
        applyStimulus(0, 0, A_PORT, 8'hAA, "rd_port_toggled");
        checkOutput("port_pad_toggled", pinOut8, 8'hAA);
        applyStimulus(0, 0, A_NONE, 8'h00, "rd_unmapped");

        $display("[TB] narrow instance");
        applyStimulus(1, 1, A_PORT, 8'hFF, "wr4_port");
        applyStimulus(1, 0, A_PORT, 8'h0F, "rd4_port");
        applyStimulus(1, 1, A_DDR,  8'hFF, "wr4_ddr");
        applyStimulus(1, 0, A_DDR,  8'h0F, "rd4_ddr");
        pinIn4 = 4'b1010;
        waitCycles(SYNC + FLT);
        applyStimulus(1, 0, A_PIN,   8'h0A, "rd4_pin");
        applyStimulus(1, 0, A_PCIFR, 8'h00, "rd4_pcifr_unmasked");
        checkOutput("irq4_unmasked", 8'(irq4), 8'h00);

        $display("[TB] masked change interrupt");
        applyStimulus(0, 1, A_PCMSK, 8'h01, "wr_pcmsk");
        pinIn8[1:0] = 2'b11;
        waitCycles(SYNC + FLT);
        checkOutput("irq_early", 8'(irq8), 8'h00);
        waitCycles(1);
        checkOutput("irq_set", 8'(irq8), 8'h01);
        applyStimulus(0, 1, A_PCIFR, 8'h00, "wr_pcifr_zero");
        checkOutput("irq_w0_keeps", 8'(irq8), 8'h01);
        applyStimulus(0, 0, A_PCIFR, 8'h01, "rd_pcifr_set");
        applyStimulus(0, 1, A_PCIFR, 8'h01, "wr_pcifr_clr");
        checkOutput("irq_clr", 8'(irq8), 8'h00);
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_clr");

        $display("[TB] mask clear keeps flag");
        pinIn8[0] = 1'b0;
        waitCycles(SYNC + FLT + 1);
        applyStimulus(0, 1, A_PCMSK, 8'h00, "wr_pcmsk_off");
        applyStimulus(0, 0, A_PCIFR, 8'h01, "rd_pcifr_sticky");
        applyStimulus(0, 1, A_PCIFR, 8'h01, "wr_pcifr_clr2");
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_clr2");

        $display("[TB] set beats same-cycle clear");
        applyStimulus(0, 1, A_PCMSK, 8'h01, "wr_pcmsk_on");
        pinIn8[0] = 1'b1;
        waitCycles(SYNC + FLT + 1);
        checkOutput("irq_pre_collide", 8'(irq8), 8'h01);
        pinIn8[0] = 1'b0;
        waitCycles(SYNC + FLT);
        applyStimulus(0, 1, A_PCIFR, 8'h01, "wr_pcifr_collide");
        applyStimulus(0, 0, A_PCIFR, 8'h01, "rd_pcifr_collide");
        checkOutput("irq_collide", 8'(irq8), 8'h01);
        applyStimulus(0, 1, A_PCIFR, 8'h01, "wr_pcifr_clr3");
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_clr3");

        $display("[TB] reset mid-run");
        applyStimulus(0, 1, A_DDR,   8'hFF, "wr_ddr_pre");
        applyStimulus(0, 1, A_PORT,  8'h3C, "wr_port_pre");
        applyStimulus(0, 1, A_PCMSK, 8'hFF, "wr_pcmsk_pre");
        pinIn8 = 8'hC3;
        waitCycles(SYNC + FLT + 1);
        checkOutput("irq_pre_reset", 8'(irq8), 8'h01);
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("ddr_pad_mid_rst", pinDdr8, 8'h00);
        checkOutput("port_pad_mid_rst", pinOut8, 8'h00);
        checkOutput("irq_mid_rst", 8'(irq8), 8'h00);
        checkOutput("io_do_mid_rst", bus8.io_do, 8'h00);
        waitCycles(3);
        sys_rst_n = 1'b1;
        waitCycles(SYNC + FLT + 2);
        applyStimulus(0, 0, A_PIN,   8'hC3, "rd_pin_post_rst");
        applyStimulus(0, 0, A_DDR,   8'h00, "rd_ddr_post_rst");
        applyStimulus(0, 0, A_PORT,  8'h00, "rd_port_post_rst");
        applyStimulus(0, 0, A_PCMSK, 8'h00, "rd_pcmsk_post_rst");
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_post_rst");
        checkOutput("irq_post_rst", 8'(irq8), 8'h00);

`ifdef GPIO_DEBOUNCE_EN
        $display("[TB] debounce");
        applyStimulus(0, 1, A_PCMSK, 8'h04, "wr_pcmsk_deb");
        pinIn8[2] = 1'b1;
        waitCycles(10);
        pinIn8[2] = 1'b0;
        waitCycles(24);
        applyStimulus(0, 0, A_PIN,   8'hC3, "rd_pin_glitch");
        applyStimulus(0, 0, A_PCIFR, 8'h00, "rd_pcifr_glitch");
        pinIn8[2] = 1'b1;
        waitCycles(SYNC + FLT);
        applyStimulus(0, 0, A_PIN,   8'hC7, "rd_pin_stable");
        waitCycles(2);
        applyStimulus(0, 0, A_PCIFR, 8'h04, "rd_pcifr_stable");
`endif

        waitCycles(2);
        checkOutput("sb_drain", 8'(sb8.size() + sb4.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
